// File: rtl/divisor_shift_sub.sv
// divisor_shift_sub
// -----------------------------------------------------------------------------
// Sequential restoring divider: unsigned 2N-bit dividend / N-bit divisor,
// one shift-subtract step per clock. Companion to the shift-add multiplier:
// the same style of (2N+1)-bit accumulator with load / shift / subtract
// controls, sequenced by a four-state control FSM.
//
// Ports
//   Clk        in   1    system clock, rising edge
//   Rst        in   1    synchronous reset, active high (wins over St)
//   St         in   1    start, sampled only while idle
//   Dividendo  in   2N   dividend, captured when St is accepted
//   Divisor    in   N    divisor, captured when St is accepted
//   Quociente  out  N    quotient  = ACC[N-1:0]
//   Resto      out  N    remainder = ACC[2N-1:N]
//   V          out  1    overflow / divide-by-zero, registered
//   Done       out  1    one-cycle completion pulse
//   Busy       out  1    high in every state except IDLE
//
// Timing (accepting edge = edge 0):
//   normal   : Done in the cycle after edge N+1
//   overflow : Done in the cycle after edge 1
// Quociente/Resto are only meaningful from Done until the next accepted St.
// -----------------------------------------------------------------------------
module divisor_shift_sub #(
  parameter int N = 4
) (
  input  logic           Clk,
  input  logic           Rst,
  input  logic           St,
  input  logic [2*N-1:0] Dividendo,
  input  logic [N-1:0]   Divisor,
  output logic [N-1:0]   Quociente,
  output logic [N-1:0]   Resto,
  output logic           V,
  output logic           Done,
  output logic           Busy
);

  // Iteration counter only has to reach N-1.
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CHECK,
    S_CALC,
    S_DONE
  } state_t;

  state_t          state, state_nx;
  logic [2*N:0]    acc, acc_nx;
  logic [N-1:0]    dreg, dreg_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic            v, v_nx;

  // Datapath for one restoring step. The upper window is N+1 bits wide so the
  // bit shifted out of the partial remainder takes part in the compare and is
  // not lost; the difference then always fits back into N bits.
  logic [2*N:0]    shifted;
  logic [N:0]      upper;
  logic [N:0]      diff;
  logic            fits;
  logic            ovf;

  always_comb begin
    shifted = acc << 1;
    upper   = shifted[2*N:N];
    fits    = (upper >= {1'b0, dreg});
    diff    = upper - {1'b0, dreg};
    // Quotient cannot fit in N bits (covers divisor == 0 as well).
    ovf     = (acc[2*N-1:N] >= dreg);
  end

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= S_IDLE;
      acc   <= '0;
      dreg  <= '0;
      cnt   <= '0;
      v     <= 1'b0;
    end else begin
      state <= state_nx;
      acc   <= acc_nx;
      dreg  <= dreg_nx;
      cnt   <= cnt_nx;
      v     <= v_nx;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state / accumulator controls
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nx = state;
    acc_nx   = acc;
    dreg_nx  = dreg;
    cnt_nx   = cnt;
    v_nx     = v;

    unique case (state)
      S_IDLE: begin
        // Outputs keep showing the previous result until a new start.
        if (St) begin
          acc_nx   = {1'b0, Dividendo};
          dreg_nx  = Divisor;
          v_nx     = 1'b0;
          state_nx = S_CHECK;
        end
      end

      S_CHECK: begin
        if (ovf) begin
          // Leave ACC untouched; the result fields are meaningless here.
          v_nx     = 1'b1;
          state_nx = S_DONE;
        end else begin
          cnt_nx   = '0;
          state_nx = S_CALC;
        end
      end

      S_CALC: begin
        // Quotient bits enter at the LSB as the remainder window slides up.
        if (fits)
          acc_nx = {diff, shifted[N-1:1], 1'b1};
        else
          acc_nx = shifted;

        if (cnt == CNT_LAST)
          state_nx = S_DONE;
        else
          cnt_nx = cnt + CW'(1);
      end

      S_DONE: begin
        state_nx = S_IDLE;
      end

      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign Quociente = acc[N-1:0];
  assign Resto     = acc[2*N-1:N];
  assign V         = v;
  assign Done      = (state == S_DONE);
  assign Busy      = (state != S_IDLE);

endmodule

// File: tb/tb_divisor_shift_sub.sv
module tb_divisor_shift_sub;

  localparam int N = 4;
  localparam int NORMAL_LAT = N + 1;
  localparam int WAIT_MAX   = 40;

  logic           Clk = 1'b0;
  logic           Rst;
  logic           St;
  logic [2*N-1:0] Dividendo;
  logic [N-1:0]   Divisor;
  logic [N-1:0]   Quociente;
  logic [N-1:0]   Resto;
  logic           V;
  logic           Done;
  logic           Busy;

  int total = 0;
  int bad   = 0;

  divisor_shift_sub #(.N(N)) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .St        (St),
    .Dividendo (Dividendo),
    .Divisor   (Divisor),
    .Quociente (Quociente),
    .Resto     (Resto),
    .V         (V),
    .Done      (Done),
    .Busy      (Busy)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Wait (sampling on negedges) until Done is seen; lat counts negedges waited.
  task automatic wait_done(output int lat, output int busy_cyc);
    lat = 0;
    busy_cyc = 0;
    while (Done !== 1'b1 && lat < WAIT_MAX) begin
      if (Busy === 1'b1) busy_cyc++;
      @(negedge Clk);
      lat++;
    end
    if (Busy === 1'b1) busy_cyc++;
    chk("done_timeout", int'(lat < WAIT_MAX), 1);
  endtask

  // Issue one start pulse; returns at the negedge of the Done cycle.
  // lat = number of edges after the accepting edge until Done is visible.
  task automatic run_div(input logic [2*N-1:0] dd, input logic [N-1:0] dv,
                         output int lat, output int busy_cyc);
    @(negedge Clk);
    Dividendo = dd;
    Divisor   = dv;
    St        = 1'b1;
    @(negedge Clk);       // accepting edge 0 has passed
    St = 1'b0;
    wait_done(lat, busy_cyc);
  endtask

  // Run one division and compare with plain integer division.
  task automatic chk_div(input int dd, input int dv);
    int lat, bc;
    int q_exp, r_exp, v_exp;
    v_exp = (dv == 0) ? 1 : ((dd / dv) > ((1 << N) - 1) ? 1 : 0);
    q_exp = (dv == 0) ? 0 : dd / dv;
    r_exp = (dv == 0) ? 0 : dd % dv;
    run_div((2*N)'(dd), N'(dv), lat, bc);
    chk($sformatf("V %0d/%0d", dd, dv), int'(V), v_exp);
    if (v_exp == 0) begin
      chk($sformatf("Q %0d/%0d", dd, dv), int'(Quociente), q_exp);
      chk($sformatf("R %0d/%0d", dd, dv), int'(Resto), r_exp);
      chk($sformatf("lat %0d/%0d", dd, dv), lat, NORMAL_LAT);
    end else begin
      chk($sformatf("lat_ovf %0d/%0d", dd, dv), lat, 1);
    end
    @(negedge Clk);
    chk("done_pulse_width", int'(Done), 0);
    chk("idle_after_done", int'(Busy), 0);
  endtask

  initial begin
    int lat, bc, seen;
    int dd, dv;

    Rst = 1'b1;
    St = 1'b1;                 // reset must win over start
    Dividendo = 8'd135;
    Divisor = 4'd13;
    repeat (2) @(negedge Clk);
    Rst = 1'b0;
    St = 1'b0;
    chk("rst_Q", int'(Quociente), 0);
    chk("rst_R", int'(Resto), 0);
    chk("rst_V", int'(V), 0);
    chk("rst_Done", int'(Done), 0);
    chk("rst_Busy", int'(Busy), 0);

    // 1: 135 / 13 with latency and busy-window checks
    run_div(8'd135, 4'd13, lat, bc);
    chk("t1_lat", lat, NORMAL_LAT);
    chk("t1_Q", int'(Quociente), 10);
    chk("t1_R", int'(Resto), 5);
    chk("t1_V", int'(V), 0);
    chk("t1_busy_cycles", bc, N + 2);   // CHECK + N x CALC + DONE
    @(negedge Clk);
    chk("t1_done_pulse", int'(Done), 0);
    chk("t1_busy_off", int'(Busy), 0);
    chk("t1_hold_Q", int'(Quociente), 10);

    // 2: boundaries
    chk_div(239, 15);
    chk_div(0, 5);

    // 3: overflow and divide by zero
    chk_div(200, 12);
    chk_div(50, 0);
    chk_div(255, 15);

    // 4: St while busy ignored, then held-high restart
    @(negedge Clk);
    Dividendo = 8'd100;
    Divisor = 4'd7;
    St = 1'b1;
    @(negedge Clk);
    St = 1'b0;
    @(negedge Clk);
    St = 1'b1;
    Dividendo = 8'd9;
    Divisor = 4'd3;
    wait_done(lat, bc);
    chk("t4_Q", int'(Quociente), 14);
    chk("t4_R", int'(Resto), 2);
    chk("t4_V", int'(V), 0);
    @(negedge Clk);
    chk("t4_idle_gap", int'(Busy), 0);
    @(negedge Clk);
    chk("t4_restart", int'(Busy), 1);
    wait_done(lat, bc);
    St = 1'b0;
    chk("t4b_Q", int'(Quociente), 3);
    chk("t4b_R", int'(Resto), 0);
    chk("t4b_V", int'(V), 0);
    @(negedge Clk);

    // 5: reset during the third CALC cycle
    Dividendo = 8'd135;
    Divisor = 4'd13;
    St = 1'b1;
    @(negedge Clk);            // CHECK
    St = 1'b0;
    repeat (3) @(negedge Clk); // CALC 1..3
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    chk("t5_Q", int'(Quociente), 0);
    chk("t5_R", int'(Resto), 0);
    chk("t5_V", int'(V), 0);
    chk("t5_Busy", int'(Busy), 0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (Done === 1'b1) seen = 1;
      @(negedge Clk);
    end
    chk("t5_no_done", seen, 0);
    chk_div(100, 7);

    // Random divisions, divisor zero included
    for (int i = 0; i < 200; i++) begin
      dd = int'($urandom_range(0, 255));
      dv = int'($urandom_range(0, 15));
      chk_div(dd, dv);
    end

    // 6: exhaustive sweep
    for (int d = 1; d < 16; d++)
      for (int x = 0; x < 256; x++)
        chk_div(x, d);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
